// File: rtl/cache_axi_arbiter_pkg.sv
// Shared AXI encodings, FSM states and grant types for the
// icache/dcache refill arbiter.
package cache_axi_arbiter_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AWW  = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [3:0] ID_I = 4'd0;
  localparam logic [3:0] ID_D = 4'd1;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic logic [3:0] owner_id(owner_e o);
    return (o == OWN_D) ? ID_D : ID_I;
  endfunction

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// Single-beat AXI4 channel bundle between the refill arbiter
// (master) and the SoC bus (slave).
interface cache_axi_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] axi_aw_addr;
  logic              axi_aw_valid;
  logic              axi_aw_ready;

  logic [63:0]       axi_w_data;
  logic [7:0]        axi_w_strb;
  logic              axi_w_valid;
  logic              axi_w_ready;

  logic              axi_b_valid;
  logic              axi_b_ready;

  logic [3:0]        axi_ar_id;
  logic [ADDR_W-1:0] axi_ar_addr;
  logic              axi_ar_valid;
  logic              axi_ar_ready;

  logic [63:0]       axi_r_data;
  logic              axi_r_valid;
  logic              axi_r_ready;

  modport master (
    output axi_aw_addr, axi_aw_valid,
    input  axi_aw_ready,
    output axi_w_data, axi_w_strb, axi_w_valid,
    input  axi_w_ready,
    input  axi_b_valid,
    output axi_b_ready,
    output axi_ar_id, axi_ar_addr, axi_ar_valid,
    input  axi_ar_ready,
    input  axi_r_data, axi_r_valid,
    output axi_r_ready
  );

  modport slave (
    input  axi_aw_addr, axi_aw_valid,
    output axi_aw_ready,
    input  axi_w_data, axi_w_strb, axi_w_valid,
    output axi_w_ready,
    output axi_b_valid,
    input  axi_b_ready,
    input  axi_ar_id, axi_ar_addr, axi_ar_valid,
    output axi_ar_ready,
    output axi_r_data, axi_r_valid,
    input  axi_r_ready
  );

endinterface

// File: rtl/cache_axi_arbiter_arb_grant.sv
// Two-way icache/dcache grant. ARB_ROUND_ROBIN_EN selects
// round-robin on contention; otherwise dcache has fixed priority.
module arb_grant
  import cache_axi_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e last_i,
  output logic   gnt_valid,
  output owner_e gnt_owner
);

  logic both;

  assign both      = i_req & d_req;
  assign gnt_valid = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e both_owner;

  // On contention the requester not served last time wins
  assign both_owner = (last_i == OWN_I) ? OWN_D : OWN_I;
`else
  owner_e both_owner;
  logic   unused_last;

  assign both_owner  = OWN_D;
  assign unused_last = last_i;
`endif

  always_comb begin
    gnt_owner = OWN_I;
    unique case (1'b1)
      both:            gnt_owner = both_owner;
      (d_req & ~i_req): gnt_owner = OWN_D;
      default:         gnt_owner = OWN_I;
    endcase
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// icache/dcache refill arbiter onto one single-beat 64-bit AXI4
// master port. Optional ARB_ROUND_ROBIN_EN enables RR grant.
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TMO_W  = 0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_ena,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [63:0]       i_data,
  output logic              i_ok,

  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  input  logic [7:0]        d_wmask,
  output logic [63:0]       d_rdata,
  output logic              d_ok,

  cache_axi_arbiter_if.master axi
);

  localparam int unused_tmo_w = TMO_W;

  logic [2:0]        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [3:0]        ar_id_q, ar_id_d;
  logic              aw_pend_q, aw_pend_d;
  logic              w_pend_q, w_pend_d;
  logic [63:0]       i_data_q, i_data_d;
  logic [63:0]       d_rdata_q, d_rdata_d;

  logic   gnt_valid;
  owner_e gnt_owner;

  arb_grant u_grant (
    .i_req     (i_ena),
    .d_req     (d_rd | d_wr),
    .last_i    (last_q),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  always_comb begin
    logic is_wr;
    is_wr     = 1'b0;
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    ar_id_d   = ar_id_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_owner;
          last_d  = gnt_owner;
          ar_id_d = owner_id(gnt_owner);
          if (gnt_owner == OWN_D) begin
            // Read+write together is treated as a write
            is_wr   = d_wr;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            wmask_d = d_wmask;
          end else begin
            addr_d  = i_addr;
          end
          aw_pend_d = is_wr;
          w_pend_d  = is_wr;
          state_d   = is_wr ? ST_AWW : ST_AR;
        end
      end
      ST_AR: begin
        if (axi.axi_ar_ready) state_d = ST_R;
      end
      ST_R: begin
        if (axi.axi_r_valid) begin
          state_d = ST_DONE;
          if (owner_q == OWN_D) d_rdata_d = axi.axi_r_data;
          else                  i_data_d  = axi.axi_r_data;
        end
      end
      ST_AWW: begin
        // AW and W retire independently, in any order
        aw_pend_d = aw_pend_q & ~axi.axi_aw_ready;
        w_pend_d  = w_pend_q & ~axi.axi_w_ready;
        if (!aw_pend_d && !w_pend_d) state_d = ST_B;
      end
      ST_B: begin
        if (axi.axi_b_valid) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      ar_id_q   <= ID_I;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      ar_id_q   <= ar_id_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign axi.axi_ar_id    = ar_id_q;
  assign axi.axi_ar_addr  = addr_q;
  assign axi.axi_ar_valid = (state_q == ST_AR);
  assign axi.axi_r_ready  = (state_q == ST_R);

  assign axi.axi_aw_addr  = addr_q;
  assign axi.axi_aw_valid = (state_q == ST_AWW) & aw_pend_q;
  assign axi.axi_w_data   = wdata_q;
  assign axi.axi_w_strb   = wmask_q;
  assign axi.axi_w_valid  = (state_q == ST_AWW) & w_pend_q;
  assign axi.axi_b_ready  = (state_q == ST_B);

  assign i_data  = i_data_q;
  assign d_rdata = d_rdata_q;
  assign i_ok    = (state_q == ST_DONE) & (owner_q == OWN_I);
  assign d_ok    = (state_q == ST_DONE) & (owner_q == OWN_D);

  a_ok_excl: assert property (
    @(posedge clk) disable iff (rst) !(i_ok && d_ok));

  a_ar_hold: assert property (
    @(posedge clk) disable iff (rst)
    (axi.axi_ar_valid && !axi.axi_ar_ready) |=>
    (axi.axi_ar_valid && $stable(axi.axi_ar_addr)));

  a_done_1: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == ST_DONE) |=> (state_q == ST_IDLE));

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter with a small
// configurable-latency single-beat AXI slave.
`timescale 1ns/1ps
module tb_cache_axi_arbiter;
  import cache_axi_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ena;
  logic [31:0] i_addr;
  logic [63:0] i_data;
  logic        i_ok;
  logic        d_rd, d_wr;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_wmask;
  logic [63:0] d_rdata;
  logic        d_ok;

  cache_axi_arbiter_if #(.ADDR_W(32)) axi ();

  cache_axi_arbiter #(.ADDR_W(32), .TMO_W(0)) dut (
    .clk(clk), .rst(rst),
    .i_ena(i_ena), .i_addr(i_addr), .i_data(i_data), .i_ok(i_ok),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_ok(d_ok),
    .axi(axi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run = 0;
  int n_fail = 0;

  int          ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0;
  logic [63:0] rdata_val = '0;
  bit          rdata_by_addr = 1'b0;

  int          ar_cnt, aw_cnt, w_cnt, r_cnt;
  bit          r_pend, aw_got, w_got;
  bit          hs_ar, hs_r, hs_aw, hs_w, hs_b;
  logic [31:0] hs_addr;
  logic [31:0] ar_log_addr[$];
  logic [3:0]  ar_log_id[$];
  logic [31:0] last_aw_addr;
  logic [63:0] last_w_data;
  logic [7:0]  last_w_strb;
  int          b_ready_cnt = 0;
  int          both_ok = 0;
  string       ok_seq = "";

  task automatic slave_clear();
    axi.axi_aw_ready = 1'b0;
    axi.axi_w_ready  = 1'b0;
    axi.axi_b_valid  = 1'b0;
    axi.axi_ar_ready = 1'b0;
    axi.axi_r_valid  = 1'b0;
    axi.axi_r_data   = '0;
    {hs_ar, hs_r, hs_aw, hs_w, hs_b} = '0;
    {r_pend, aw_got, w_got} = '0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
  endtask

  // Slave acts on the falling edge; handshakes seen then
  // complete at the following rising edge.
  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_clear();
      end else begin
        if (hs_ar) begin r_pend = 1'b1; r_cnt = 0; ar_cnt = 0; end
        if (hs_r) axi.axi_r_valid = 1'b0;
        if (hs_aw) begin aw_got = 1'b1; aw_cnt = 0; end
        if (hs_w) begin w_got = 1'b1; w_cnt = 0; end
        if (hs_b) axi.axi_b_valid = 1'b0;

        axi.axi_ar_ready = axi.axi_ar_valid && (ar_cnt >= ar_delay);
        if (axi.axi_ar_valid && !axi.axi_ar_ready) ar_cnt++;
        axi.axi_aw_ready = axi.axi_aw_valid && (aw_cnt >= aw_delay);
        if (axi.axi_aw_valid && !axi.axi_aw_ready) aw_cnt++;
        axi.axi_w_ready = axi.axi_w_valid && (w_cnt >= w_delay);
        if (axi.axi_w_valid && !axi.axi_w_ready) w_cnt++;

        if (r_pend) begin
          if (r_cnt >= r_delay) begin
            axi.axi_r_valid = 1'b1;
            axi.axi_r_data  = rdata_by_addr ? {hs_addr, ~hs_addr} : rdata_val;
            r_pend = 1'b0;
          end else begin
            r_cnt++;
          end
        end
        if (aw_got && w_got) begin
          axi.axi_b_valid = 1'b1;
          aw_got = 1'b0;
          w_got  = 1'b0;
        end

        hs_ar = axi.axi_ar_valid && axi.axi_ar_ready;
        if (hs_ar) begin
          ar_log_addr.push_back(axi.axi_ar_addr);
          ar_log_id.push_back(axi.axi_ar_id);
          hs_addr = axi.axi_ar_addr;
        end
        hs_r  = axi.axi_r_valid && axi.axi_r_ready;
        hs_aw = axi.axi_aw_valid && axi.axi_aw_ready;
        if (hs_aw) last_aw_addr = axi.axi_aw_addr;
        hs_w  = axi.axi_w_valid && axi.axi_w_ready;
        if (hs_w) begin
          last_w_data = axi.axi_w_data;
          last_w_strb = axi.axi_w_strb;
        end
        hs_b  = axi.axi_b_valid && axi.axi_b_ready;
        if (axi.axi_b_ready) b_ready_cnt++;
      end
      if (i_ok && d_ok) both_ok++;
      if (i_ok) ok_seq = {ok_seq, "I"};
      if (d_ok) ok_seq = {ok_seq, "D"};
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_ok(input int max, output bit gi, output bit gd,
                         output int c);
    gi = 1'b0; gd = 1'b0; c = -1;
    for (int k = 0; k < max; k++) begin
      tick();
      if (i_ok || d_ok) begin
        gi = i_ok; gd = d_ok; c = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_ena = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    n_run++;
    if ({axi.axi_ar_valid, axi.axi_aw_valid, axi.axi_w_valid,
         axi.axi_r_ready, axi.axi_b_ready} !== 5'b0)
      $display("FAIL reset_valids: got %b want 00000",
        {axi.axi_ar_valid, axi.axi_aw_valid, axi.axi_w_valid,
         axi.axi_r_ready, axi.axi_b_ready});
    if ({axi.axi_ar_valid, axi.axi_aw_valid, axi.axi_w_valid,
         axi.axi_r_ready, axi.axi_b_ready} !== 5'b0) n_fail++;
    n_run++;
    if ({i_ok, d_ok} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ok: got %b want 00", {i_ok, d_ok});
    end
    n_run++;
    if (i_data !== 64'h0 || d_rdata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h want 0/0", i_data, d_rdata);
    end
    n_run++;
    if (axi.axi_ar_addr !== 32'h0 || axi.axi_aw_addr !== 32'h0 ||
        axi.axi_w_strb !== 8'h0 || axi.axi_ar_id !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got ar %h aw %h strb %h id %0d want 0",
        axi.axi_ar_addr, axi.axi_aw_addr, axi.axi_w_strb, axi.axi_ar_id);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_icache_read();
    bit gi, gd; int c, c0;
    rdata_by_addr = 1'b0;
    rdata_val = 64'h0000_0013_0000_0093;
    i_addr = 32'h8000_0000;
    i_ena = 1'b1;
    c0 = cyc;
    tick();
    n_run++;
    if (axi.axi_ar_valid !== 1'b1 || axi.axi_ar_addr !== 32'h8000_0000 ||
        axi.axi_ar_id !== 4'd0) begin
      n_fail++;
      $display("FAIL i_ar: got v%b %h id%0d want v1 80000000 id0",
        axi.axi_ar_valid, axi.axi_ar_addr, axi.axi_ar_id);
    end
    wait_ok(20, gi, gd, c);
    i_ena = 1'b0;
    n_run++;
    if (!gi || gd || c != c0 + 3) begin
      n_fail++;
      $display("FAIL i_lat: got i%b d%b cyc %0d want i1 d0 cyc %0d",
        gi, gd, c, c0 + 3);
    end
    n_run++;
    if (i_data !== 64'h0000_0013_0000_0093) begin
      n_fail++;
      $display("FAIL i_data: got %h want 0000001300000093", i_data);
    end
    tick();
    n_run++;
    if (i_ok !== 1'b0 || i_data !== 64'h0000_0013_0000_0093) begin
      n_fail++;
      $display("FAIL i_pulse: got ok %b data %h want ok 0 data held",
        i_ok, i_data);
    end
  endtask

  task automatic test_dcache_write();
    bit gi, gd; int c, c0;
    aw_delay = 0; w_delay = 2;
    b_ready_cnt = 0;
    d_addr  = 32'h8000_1000;
    d_wdata = 64'h1122_3344_5566_7788;
    d_wmask = 8'h0F;
    d_wr = 1'b1;
    c0 = cyc;
    tick();
    n_run++;
    if (axi.axi_aw_valid !== 1'b1 || axi.axi_w_valid !== 1'b1 ||
        axi.axi_ar_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rise: got aw%b w%b ar%b want aw1 w1 ar0",
        axi.axi_aw_valid, axi.axi_w_valid, axi.axi_ar_valid);
    end
    tick();
    n_run++;
    if (axi.axi_aw_valid !== 1'b0 || axi.axi_w_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_indep: got aw%b w%b want aw0 w1",
        axi.axi_aw_valid, axi.axi_w_valid);
    end
    wait_ok(20, gi, gd, c);
    d_wr = 1'b0;
    n_run++;
    if (gi || !gd || c != c0 + 5) begin
      n_fail++;
      $display("FAIL wr_lat: got i%b d%b cyc %0d want i0 d1 cyc %0d",
        gi, gd, c, c0 + 5);
    end
    n_run++;
    if (last_w_strb !== 8'h0F || last_w_data !== 64'h1122_3344_5566_7788 ||
        last_aw_addr !== 32'h8000_1000) begin
      n_fail++;
      $display("FAIL wr_beat: got strb %h data %h addr %h want 0f 1122334455667788 80001000",
        last_w_strb, last_w_data, last_aw_addr);
    end
    tick();
    n_run++;
    if (b_ready_cnt != 1 || d_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_b: got b_ready cycles %0d d_ok %b want 1 and 0",
        b_ready_cnt, d_ok);
    end
    w_delay = 0;
  endtask

  task automatic test_priority();
    bit gi, gd; int c1, c2;
    do_reset();
    rdata_by_addr = 1'b1;
    ar_log_addr.delete();
    ar_log_id.delete();
    i_addr = 32'h0000_0200;
    d_addr = 32'h0000_0100;
    i_ena = 1'b1;
    d_rd  = 1'b1;
    wait_ok(20, gi, gd, c1);
    d_rd = 1'b0;
    n_run++;
    if (gi || !gd || d_rdata !== {32'h100, ~32'h100}) begin
      n_fail++;
      $display("FAIL prio_first: got i%b d%b rdata %h want d first %h",
        gi, gd, d_rdata, {32'h100, ~32'h100});
    end
    wait_ok(20, gi, gd, c2);
    i_ena = 1'b0;
    n_run++;
    if (!gi || gd || c2 != c1 + 4) begin
      n_fail++;
      $display("FAIL prio_second: got i%b d%b gap %0d want i1 d0 gap 4",
        gi, gd, c2 - c1);
    end
    n_run++;
    if (i_data !== {32'h200, ~32'h200}) begin
      n_fail++;
      $display("FAIL prio_idata: got %h want %h", i_data, {32'h200, ~32'h200});
    end
    n_run++;
    if (ar_log_id.size() != 2 || ar_log_id[0] !== ID_D ||
        ar_log_id[1] !== ID_I || ar_log_addr[0] !== 32'h100) begin
      n_fail++;
      $display("FAIL prio_ar_order: got %0d ARs want D@100 then I@200",
        ar_log_id.size());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit gi, gd; int c;
    do_reset();
    ok_seq = "";
    both_ok = 0;
    i_addr = 32'h0000_1000;
    d_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      i_ena = 1'b1;
      d_rd  = 1'b1;
      wait_ok(20, gi, gd, c);
      if (gd) d_rd = 1'b0;
      if (gi) i_ena = 1'b0;
      wait_ok(20, gi, gd, c);
      d_rd  = 1'b0;
      i_ena = 1'b0;
      tick();
    end
    n_run++;
    if (ok_seq != "DIDIDIDI") begin
      n_fail++;
      $display("FAIL b2b_order: got %s want DIDIDIDI", ok_seq);
    end
    n_run++;
    if (both_ok != 0) begin
      n_fail++;
      $display("FAIL b2b_ok_excl: got %0d dual-ok cycles want 0", both_ok);
    end
  endtask

  task automatic test_last_grant();
    bit gi, gd; int c;
    string want;
`ifdef ARB_ROUND_ROBIN_EN
    want = "DID";
`else
    want = "DDI";
`endif
    do_reset();
    ok_seq = "";
    d_addr = 32'h0000_0300;
    i_addr = 32'h0000_0400;
    d_rd = 1'b1;
    wait_ok(20, gi, gd, c);
    d_rd = 1'b0;
    tick();
    i_ena = 1'b1;
    d_rd  = 1'b1;
    wait_ok(20, gi, gd, c);
    if (gd) d_rd = 1'b0;
    if (gi) i_ena = 1'b0;
    wait_ok(20, gi, gd, c);
    d_rd  = 1'b0;
    i_ena = 1'b0;
    tick();
    n_run++;
    if (ok_seq != want) begin
      n_fail++;
      $display("FAIL last_grant: got %s want %s", ok_seq, want);
    end
  endtask

  task automatic test_ar_stall();
    bit gi, gd; int c, c0;
    bit bad;
    do_reset();
    rdata_by_addr = 1'b0;
    rdata_val = 64'hDEAD_BEEF_0BAD_F00D;
    ar_delay = 5;
    i_addr = 32'h8000_0040;
    i_ena = 1'b1;
    c0 = cyc;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (axi.axi_ar_valid !== 1'b1 || axi.axi_ar_addr !== 32'h8000_0040)
        bad = 1'b1;
    end
    n_run++;
    if (bad) begin
      n_fail++;
      $display("FAIL ar_stable: got v%b addr %h want v1 80000040 held",
        axi.axi_ar_valid, axi.axi_ar_addr);
    end
    wait_ok(20, gi, gd, c);
    i_ena = 1'b0;
    n_run++;
    if (!gi || c != c0 + 8 || i_data !== 64'hDEAD_BEEF_0BAD_F00D) begin
      n_fail++;
      $display("FAIL ar_stall_ok: got i%b cyc %0d data %h want i1 cyc %0d deadbeef0badf00d",
        gi, c, i_data, c0 + 8);
    end
    ar_delay = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit gi, gd; int c, c0;
    r_delay = 10;
    rdata_val = 64'h0123_4567_89AB_CDEF;
    i_addr = 32'h8000_0080;
    i_ena = 1'b1;
    tick();
    tick();
    n_run++;
    if (axi.axi_r_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_in_r: got r_ready %b want 1", axi.axi_r_ready);
    end
    rst = 1'b1;
    #1;
    n_run++;
    if ({axi.axi_ar_valid, axi.axi_aw_valid, axi.axi_w_valid,
         axi.axi_r_ready, axi.axi_b_ready, i_ok, d_ok} !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_async: got %b want 0000000",
        {axi.axi_ar_valid, axi.axi_aw_valid, axi.axi_w_valid,
         axi.axi_r_ready, axi.axi_b_ready, i_ok, d_ok});
    end
    n_run++;
    if (i_data !== 64'h0) begin
      n_fail++;
      $display("FAIL mid_data: got %h want 0", i_data);
    end
    i_ena = 1'b0;
    r_delay = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    i_addr = 32'h8000_00C0;
    i_ena = 1'b1;
    c0 = cyc;
    wait_ok(20, gi, gd, c);
    i_ena = 1'b0;
    n_run++;
    if (!gi || c != c0 + 3 || i_data !== 64'h0123_4567_89AB_CDEF) begin
      n_fail++;
      $display("FAIL mid_fresh: got i%b cyc %0d data %h want i1 cyc %0d 0123456789abcdef",
        gi, c, i_data, c0 + 3);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    i_ena = 1'b0; i_addr = '0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0;
    d_wdata = '0; d_wmask = '0;
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_priority();
    test_back_to_back();
    test_last_grant();
    test_ar_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog");
  end

endmodule
